iob_eth_tx_framer: RTL and testbench
====================================

// Module: iob_eth_tx_framer
// PURPOSE
//  MII transmit framer: takes frame bytes (dest MAC .. payload) from the TX buffer and drives MII nibbles.
//  Adds preamble, SFD, zero padding to the minimum frame length, CRC-32 FCS and the inter-frame gap.
//  Sits between the TX frame buffer and the PHY TX pins (TX_EN/TX_DATA); runs in the TX_CLK domain.
// PARAMETERS
//  BUF_ADDR_W   11   TX buffer address width; also the width of nbytes
//  PREAMBLE_LEN 7    preamble bytes of 0x55 sent before the SFD byte 0xD5
//  MIN_FRAME    60   minimum bytes before FCS; shorter frames are zero-padded; 0 disables padding
//  IFG_NIBBLES  24   idle nibble cycles after the FCS before done/ready (12 byte times)
// PORTS
//  clk        in  1           MII TX clock; the only clock
//  rst        in  1           synchronous, active-high reset
//  start      in  1           1-cycle send request; nbytes sampled on the same edge
//  nbytes     in  BUF_ADDR_W  frame length in bytes, excluding preamble, SFD and FCS
//  busy       out 1           high from the cycle after an accepted start until done
//  done       out 1           1-cycle pulse at the end of the IFG
//  buf_rd_en  out 1           TX buffer read strobe
//  buf_addr   out BUF_ADDR_W  TX buffer byte address, 0-based
//  buf_data   in  8           buffer read data; valid the cycle after buf_rd_en
//  tx_en      out 1           MII TX_EN
//  tx_data    out 4           MII TX_DATA; low nibble of each byte goes first
// BEHAVIOUR
//  - Reset: all outputs 0 (busy, done, buf_rd_en, buf_addr, tx_en, tx_data). State goes to IDLE.
//  - Reset mid-frame aborts the frame: tx_en is 0 from the edge where rst is seen. No done pulse.
//  - FSM states: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
//  - PAD is skipped when nbytes >= MIN_FRAME.
//  - Start acceptance: start is accepted only in IDLE with nbytes != 0.
//    Otherwise start is ignored: no busy, no done.
//  - Latency: start accepted at edge k -> tx_en=1 with tx_data=4'h5 at cycle k+1.
//  - PRE: 2*PREAMBLE_LEN nibbles of 4'h5.
//  - SFD: nibble 4'h5, then 4'hD.
//  - DATA: byte i is sent as two nibbles, low nibble then high nibble.
//  - Buffer fetch: the read for byte i+1 is issued on the low-nibble cycle of byte i.
//    Byte 0 is read during the last PRE nibble.
//  - Buffer reads: the address is never outside 0..nbytes-1, and no reads happen in PAD, FCS or IFG.
//  - PAD: 2*(MIN_FRAME-nbytes) nibbles of 4'h0. Pad bytes are included in the CRC.
//  - CRC-32 (IEEE 802.3):
//    * reflected polynomial 0xEDB88320, init 0xFFFFFFFF;
//    * updated once per byte over DATA and PAD bytes;
//    * FCS = ~crc, sent LSB byte first, each byte low nibble first.
//  - FCS: 8 nibbles. tx_en drops to 0 on the cycle after the last FCS nibble.
//  - IFG: IFG_NIBBLES cycles with tx_en=0 and tx_data=0. done pulses on the final IFG cycle.
//    busy falls on the next cycle, when the FSM is back in IDLE.
//  - Frame length: tx_en high for 2*PREAMBLE_LEN + 2 + 2*max(nbytes,MIN_FRAME) + 8 cycles, contiguous, no gaps.
//  - Simultaneous start and done: start is ignored (state is not yet IDLE). The next start is accepted one cycle later.
//  - nbytes changing while busy has no effect, because the value was latched at start.
//  - Wrap-around: the byte counter is BUF_ADDR_W wide. nbytes = 2^BUF_ADDR_W-1 is legal and the address must not wrap.
// STRUCTURE
//  - Shared constants in iob_eth_defs.vh:
//    * ETH_PREAMBLE_NIBBLE 4'h5, ETH_SFD 8'hD5;
//    * ETH_CRC_POLY 32'hEDB88320, ETH_CRC_INIT 32'hFFFFFFFF;
//    * state encodings as `define values.
//  - Sub-module iob_eth_crc32:
//    * combinational next-CRC for one byte, plus a 32-bit register;
//    * ports clk, rst, init, en, data[7:0], crc[31:0];
//    * shared with the future RX deframer FCS checker.
//  - Framer: FSM, nibble toggle, byte counter, latched nbytes, IFG counter and nibble mux.
// TESTING
//  - Reset: rst held 5 cycles -> all outputs 0.
//    Release and 20 idle cycles -> tx_en stays 0 and buf_rd_en stays 0.
//  - Known CRC:
//    * setup: MIN_FRAME=0 instance, buffer "123456789", nbytes=9, start;
//    * tx_data sequence: 14x5, 5, D, then 1,3,2,3,...,9,3;
//    * FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926);
//    * tx_en high for exactly 42 cycles; done pulses once, 24 cycles after tx_en falls.
//  - Padding:
//    * MIN_FRAME=60, nbytes=14 (dest/src MAC, type 0x0800);
//    * response: 92 zero nibbles after the data, tx_en high 144 cycles;
//    * FCS equals a software CRC of the 60 bytes; exactly 14 buffer reads.
//  - Start handling:
//    * start while busy -> ignored, and the frame in flight is unchanged;
//    * start with nbytes=0 -> no busy, no tx_en;
//    * start on the cycle after busy falls -> accepted.
//  - Reset mid-frame:
//    * rst asserted during DATA byte 5 -> tx_en=0 the next cycle and no done pulse;
//    * a following frame with nbytes=64 completes correctly.
//  - Back-to-back:
//    * two frames (nbytes=64, then 100), start issued on the cycle after each done;
//    * response: the gap between frames is 24 idle cycles + 1 start cycle, and both FCS values are correct.

Source files
------------

// File: rtl/iob_eth_tx_framer_pkg.sv
// Shared Ethernet TX constants, framer state encoding and the byte-wise CRC-32 step.
package iob_eth_tx_framer_pkg;

  localparam logic [3:0]  ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [7:0]  ETH_SFD             = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT        = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_tx_framer_crc32.sv
// Registered CRC-32 accumulator, one byte per enabled cycle; shared with the RX FCS checker.
module iob_eth_crc32
  import iob_eth_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= ETH_CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/iob_eth_tx_framer.sv
// MII transmit framer: preamble, SFD, buffered payload, zero padding, FCS and inter-frame gap.
module iob_eth_tx_framer
  import iob_eth_tx_framer_pkg::*;
#(
  parameter int BUF_ADDR_W   = 11,
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_NIBBLES  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BUF_ADDR_W-1:0] nbytes,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_rd_en,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  input  logic [7:0]            buf_data,
  output logic                  tx_en,
  output logic [3:0]            tx_data
);

  localparam int CNT_W = 16;

  tx_state_t             state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  nib;
  logic [BUF_ADDR_W-1:0] byte_cnt;
  logic [BUF_ADDR_W-1:0] len;
  logic [7:0]            data_q;
  logic                  rd_q;
  logic [31:0]           crc;
  logic [31:0]           fcs_sh;
  logic                  crc_en;
  logic [7:0]            crc_data;
  logic                  accept;
  logic                  last_pre, last_byte, last_pad, last_fcs, last_ifg, need_pad;

  assign accept    = (state == ST_IDLE) && start && (nbytes != '0);
  assign last_pre  = (cnt == CNT_W'(2 * PREAMBLE_LEN - 1));
  assign last_byte = (byte_cnt == len - BUF_ADDR_W'(1));
  assign last_pad  = (byte_cnt == BUF_ADDR_W'(MIN_FRAME - 1));
  assign last_fcs  = (cnt == CNT_W'(7));
  assign last_ifg  = (cnt == CNT_W'(IFG_NIBBLES - 1));
  assign need_pad  = (MIN_FRAME > 0) && (32'(len) < 32'(MIN_FRAME));

  assign crc_en   = nib && ((state == ST_DATA) || (state == ST_PAD));
  assign crc_data = (state == ST_DATA) ? data_q : 8'h00;
  assign fcs_sh   = (~crc) >> {cnt[2:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Fetch runs one nibble-pair ahead: byte i+1 is read on the low nibble of byte i,
  // captured one cycle later so data_q switches exactly at the byte boundary.
  always_comb begin
    state_next = state;
    buf_rd_en  = 1'b0;
    buf_addr   = '0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    tx_en      = 1'b0;
    tx_data    = 4'h0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_PRE;
      end
      ST_PRE: begin
        tx_en   = 1'b1;
        tx_data = ETH_PREAMBLE_NIBBLE;
        if (last_pre) begin
          buf_rd_en  = 1'b1;
          state_next = ST_SFD;
        end
      end
      ST_SFD: begin
        tx_en   = 1'b1;
        tx_data = nib ? ETH_SFD[7:4] : ETH_SFD[3:0];
        if (nib) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_en   = 1'b1;
        tx_data = nib ? data_q[7:4] : data_q[3:0];
        if (!nib && !last_byte) begin
          buf_rd_en = 1'b1;
          buf_addr  = byte_cnt + BUF_ADDR_W'(1);
        end
        if (nib && last_byte) state_next = need_pad ? ST_PAD : ST_FCS;
      end
      ST_PAD: begin
        tx_en = 1'b1;
        if (nib && last_pad) state_next = ST_FCS;
      end
      ST_FCS: begin
        tx_en   = 1'b1;
        tx_data = fcs_sh[3:0];
        if (last_fcs) state_next = ST_IFG;
      end
      ST_IFG: begin
        if (last_ifg) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      nib      <= 1'b0;
      byte_cnt <= '0;
      len      <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
    end else begin
      cnt  <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      nib  <= (state inside {ST_SFD, ST_DATA, ST_PAD}) ? ~nib : 1'b0;
      rd_q <= buf_rd_en;
      if (state inside {ST_DATA, ST_PAD}) begin
        if (nib) byte_cnt <= byte_cnt + BUF_ADDR_W'(1);
      end else begin
        byte_cnt <= '0;
      end
      if (accept) len <= nbytes;
      if (rd_q) data_q <= buf_data;
    end
  end

  iob_eth_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (crc_en),
    .data (crc_data),
    .crc  (crc)
  );

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// Directed bench: one unpadded instance for the known CRC, one padded instance for the rest.
module tb_iob_eth_tx_framer;

  logic clk = 1'b0;
  logic rst;

  logic        start0, busy0, done0, rd0, en0;
  logic [10:0] nbytes0, addr0;
  logic [7:0]  data0 = 8'h00;
  logic [3:0]  txd0;

  logic        start1, busy1, done1, rd1, en1;
  logic [10:0] nbytes1, addr1;
  logic [7:0]  data1 = 8'h00;
  logic [3:0]  txd1;

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] q0[$], q1[$], exp_q[$];
  int en_cnt0 = 0, rise0 = 0, last_en0 = 0, done_cnt0 = 0, done_cyc0 = 0;
  int rd_cnt0 = 0, bad0 = 0, seg0 = 0, busy_cnt0 = 0, len0 = 0;
  int en_cnt1 = 0, rise1 = 0, last_en1 = 0, done_cnt1 = 0, done_cyc1 = 0;
  int rd_cnt1 = 0, bad1 = 0, seg1 = 0, busy_cnt1 = 0, len1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  iob_eth_tx_framer #(.BUF_ADDR_W(11), .PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_NIBBLES(24)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .nbytes(nbytes0), .busy(busy0), .done(done0),
    .buf_rd_en(rd0), .buf_addr(addr0), .buf_data(data0), .tx_en(en0), .tx_data(txd0)
  );

  iob_eth_tx_framer #(.BUF_ADDR_W(11), .PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_NIBBLES(24)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .nbytes(nbytes1), .busy(busy1), .done(done1),
    .buf_rd_en(rd1), .buf_addr(addr1), .buf_data(data1), .tx_en(en1), .tx_data(txd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) data0 <= mem0[addr0];
    if (rd1) data1 <= mem1[addr1];
  end

  always @(negedge clk) begin
    if (en0) begin q0.push_back(txd0); en_cnt0++; last_en0 = cyc; end
    if (en0 && !prev0) begin seg0++; rise0 = cyc; end
    prev0 = en0;
    if (done0) begin done_cnt0++; done_cyc0 = cyc; end
    if (rd0) begin rd_cnt0++; if (32'(addr0) >= len0) bad0++; end
    if (busy0) busy_cnt0++;
    if (en1) begin q1.push_back(txd1); en_cnt1++; last_en1 = cyc; end
    if (en1 && !prev1) begin seg1++; rise1 = cyc; end
    prev1 = en1;
    if (done1) begin done_cnt1++; done_cyc1 = cyc; end
    if (rd1) begin rd_cnt1++; if (32'(addr1) >= len1) bad1++; end
    if (busy1) busy_cnt1++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input bit sel, input int limit);
    int base;
    bit got;
    base = sel ? done_cnt1 : done_cnt0;
    got  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((sel ? done_cnt1 : done_cnt0) != base) begin got = 1'b1; break; end
    end
    chk(sel ? "done_wait1" : "done_wait0", 32'(got), 32'd1);
  endtask

  // Bit-serial reference CRC over data bytes plus zero padding.
  task automatic build_exp(input bit sel, input int n, input int minf);
    int tot;
    logic [31:0] c;
    logic [7:0] b;
    logic fb;
    exp_q.delete();
    tot = (n > minf) ? n : minf;
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < tot; i++) begin
      b = (i < n) ? (sel ? mem1[i] : mem0[i]) : 8'h00;
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
  endtask

  task automatic check_frame(input string tag, input bit sel, input int qb, input int n, input int minf);
    int sz;
    build_exp(sel, n, minf);
    sz = (sel ? q1.size() : q0.size()) - qb;
    chk({tag, "_len"}, sz, exp_q.size());
    if (sz == exp_q.size()) begin
      for (int i = 0; i < sz; i++) chk({tag, "_nib"}, 32'(sel ? q1[qb+i] : q0[qb+i]), 32'(exp_q[i]));
    end
  endtask

  int qb, b_en, b_rd, b_done, b_seg, b_busy, b_bad, t0, d_cyc, l_en;
  logic [31:0] fcs;

  initial begin
    rst = 1'b1;
    start0 = 1'b0; nbytes0 = '0;
    start1 = 1'b0; nbytes1 = '0;
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'(i * 7 + 3);
    end
    for (int i = 0; i < 9; i++) mem0[i] = 8'(8'h31 + i);
    mem1[0] = 8'h00; mem1[1] = 8'h11; mem1[2]  = 8'h22; mem1[3]  = 8'h33; mem1[4]  = 8'h44;
    mem1[5] = 8'h55; mem1[6] = 8'h66; mem1[7]  = 8'h77; mem1[8]  = 8'h88; mem1[9]  = 8'h99;
    mem1[10] = 8'hAA; mem1[11] = 8'hBB; mem1[12] = 8'h08; mem1[13] = 8'h00;

    // Reset held for 5 cycles
    repeat (5) step();
    chk("rst_busy0", 32'(busy0), 0);  chk("rst_done0", 32'(done0), 0);
    chk("rst_rd0", 32'(rd0), 0);      chk("rst_addr0", 32'(addr0), 0);
    chk("rst_en0", 32'(en0), 0);      chk("rst_txd0", 32'(txd0), 0);
    chk("rst_busy1", 32'(busy1), 0);  chk("rst_done1", 32'(done1), 0);
    chk("rst_rd1", 32'(rd1), 0);      chk("rst_addr1", 32'(addr1), 0);
    chk("rst_en1", 32'(en1), 0);      chk("rst_txd1", 32'(txd1), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("idle_en0", en_cnt0, 0); chk("idle_rd0", rd_cnt0, 0);
    chk("idle_en1", en_cnt1, 0); chk("idle_rd1", rd_cnt1, 0);

    // Known CRC: "123456789" -> 0xCBF43926
    qb = q0.size(); b_en = en_cnt0; b_rd = rd_cnt0; b_done = done_cnt0; b_seg = seg0;
    nbytes0 = 11'd9; len0 = 9; t0 = cyc;
    start0 = 1'b1; step(); start0 = 1'b0;
    wait_done(1'b0, 200);
    chk("crc9_busy_at_done", 32'(busy0), 1);
    step();
    chk("crc9_busy_after", 32'(busy0), 0);
    chk("crc9_done_after", 32'(done0), 0);
    repeat (3) step();
    check_frame("crc9", 1'b0, qb, 9, 0);
    fcs = '0;
    if (q0.size() - qb == 42) for (int k = 0; k < 8; k++) fcs[4*k +: 4] = q0[qb + 34 + k];
    chk("crc9_fcs", fcs, 32'hCBF43926);
    chk("crc9_en_cycles", en_cnt0 - b_en, 42);
    chk("crc9_segments", seg0 - b_seg, 1);
    chk("crc9_done_count", done_cnt0 - b_done, 1);
    chk("crc9_done_delay", done_cyc0 - last_en0, 24);
    chk("crc9_latency", rise0, t0 + 1);
    chk("crc9_reads", rd_cnt0 - b_rd, 9);
    chk("crc9_bad_addr", bad0, 0);

    // Start with nbytes=0 is ignored
    b_busy = busy_cnt1; b_en = en_cnt1; b_done = done_cnt1;
    nbytes1 = 11'd0; start1 = 1'b1; step(); start1 = 1'b0;
    repeat (10) step();
    chk("zero_busy", busy_cnt1 - b_busy, 0);
    chk("zero_en", en_cnt1 - b_en, 0);
    chk("zero_done", done_cnt1 - b_done, 0);

    // Start and nbytes change while busy leave the frame in flight untouched
    qb = q1.size(); b_en = en_cnt1; b_done = done_cnt1;
    nbytes1 = 11'd20; len1 = 20;
    start1 = 1'b1; step(); start1 = 1'b0;
    repeat (40) step();
    nbytes1 = 11'd5; start1 = 1'b1; step(); start1 = 1'b0;
    wait_done(1'b1, 400);
    d_cyc = done_cyc1;
    check_frame("busy_start", 1'b1, qb, 20, 60);
    chk("busy_start_done", done_cnt1 - b_done, 1);

    // Start raised in the done cycle is ignored, held one more cycle it is accepted
    qb = q1.size(); b_en = en_cnt1; b_rd = rd_cnt1; b_done = done_cnt1; b_seg = seg1;
    nbytes1 = 11'd14; len1 = 14; start1 = 1'b1;
    step();
    chk("busy_fell", 32'(busy1), 0);
    step();
    start1 = 1'b0;
    wait_done(1'b1, 400);
    check_frame("pad14", 1'b1, qb, 14, 60);
    chk("pad14_latency", rise1, d_cyc + 2);
    chk("pad14_en_cycles", en_cnt1 - b_en, 144);
    chk("pad14_reads", rd_cnt1 - b_rd, 14);
    chk("pad14_bad_addr", bad1, 0);
    chk("pad14_segments", seg1 - b_seg, 1);
    chk("pad14_done_count", done_cnt1 - b_done, 1);

    // Reset during DATA byte 5 aborts the frame
    repeat (3) step();
    b_en = en_cnt1; b_done = done_cnt1;
    nbytes1 = 11'd64; len1 = 64;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 100 && (en_cnt1 - b_en) < 27; i++) step();
    chk("abort_reached", en_cnt1 - b_en, 27);
    rst = 1'b1;
    step();
    chk("abort_en", 32'(en1), 0);
    chk("abort_busy", 32'(busy1), 0);
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("abort_no_done", done_cnt1 - b_done, 0);
    chk("abort_en_total", en_cnt1 - b_en, 27);

    qb = q1.size(); b_en = en_cnt1; b_rd = rd_cnt1; b_bad = bad1;
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_done(1'b1, 400);
    check_frame("after_abort", 1'b1, qb, 64, 60);
    chk("after_abort_en", en_cnt1 - b_en, 152);
    chk("after_abort_reads", rd_cnt1 - b_rd, 64);
    chk("after_abort_bad", bad1 - b_bad, 0);

    // Back-to-back 64 then 100 bytes, each start on the cycle after done
    step();
    qb = q1.size(); b_en = en_cnt1; b_rd = rd_cnt1;
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_done(1'b1, 400);
    check_frame("b2b_64", 1'b1, qb, 64, 60);
    chk("b2b_64_reads", rd_cnt1 - b_rd, 64);
    l_en = last_en1;
    step();
    qb = q1.size(); b_en = en_cnt1; b_rd = rd_cnt1;
    nbytes1 = 11'd100; len1 = 100;
    start1 = 1'b1; step(); start1 = 1'b0;
    wait_done(1'b1, 600);
    check_frame("b2b_100", 1'b1, qb, 100, 60);
    chk("b2b_100_en", en_cnt1 - b_en, 224);
    chk("b2b_100_reads", rd_cnt1 - b_rd, 100);
    chk("b2b_gap", rise1 - l_en - 1, 25);
    chk("b2b_bad_addr", bad1, 0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
